// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT: settles after each v_ref change, averages PV power
// over a window, then steps v_ref toward higher power within a clamped range.
module mppt_po_controller #(
  parameter int                            DATA_WIDTH     = 32,
  parameter logic signed [DATA_WIDTH-1:0]  V_REF_INIT     = 32'h0012_0000,
  parameter logic signed [DATA_WIDTH-1:0]  V_REF_MIN      = 32'h0005_0000,
  parameter logic signed [DATA_WIDTH-1:0]  V_REF_MAX      = 32'h0028_0000,
  parameter logic signed [DATA_WIDTH-1:0]  V_STEP         = 32'h0000_8000,
  parameter logic signed [DATA_WIDTH-1:0]  P_DEADBAND     = 32'h0000_4000,
  parameter int                            SETTLE_SAMPLES = 4,
  parameter int                            AVG_LOG2       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] v_pv,
  input  logic signed [DATA_WIDTH-1:0] i_pv,
  output logic signed [DATA_WIDTH-1:0] v_ref,
  output logic                         v_ref_valid,
  output logic signed [DATA_WIDTH-1:0] p_avg,
  output logic                         dir_up,
  output logic                         busy
);

  localparam int FRAC    = DATA_WIDTH / 2;
  localparam int ACC_W   = DATA_WIDTH + AVG_LOG2;
  localparam int AVG_N   = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_SAMPLES > AVG_N) ? SETTLE_SAMPLES : AVG_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] AVG_LAST    = CNT_W'(AVG_N - 1);

  localparam logic signed [DATA_WIDTH-1:0] P_POS_SAT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] P_NEG_SAT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // One-bit-wider copies so step and power-delta comparisons cannot wrap.
  localparam logic signed [DATA_WIDTH:0] REF_MAX_X = {V_REF_MAX[DATA_WIDTH-1], V_REF_MAX};
  localparam logic signed [DATA_WIDTH:0] REF_MIN_X = {V_REF_MIN[DATA_WIDTH-1], V_REF_MIN};
  localparam logic signed [DATA_WIDTH:0] STEP_X    = {V_STEP[DATA_WIDTH-1], V_STEP};
  localparam logic signed [DATA_WIDTH:0] DB_POS    = {P_DEADBAND[DATA_WIDTH-1], P_DEADBAND};
  localparam logic signed [DATA_WIDTH:0] DB_NEG    = -DB_POS;

  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, COMPUTE, UPDATE} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic signed [ACC_W-1:0]        acc;
  logic signed [DATA_WIDTH-1:0]   p_prev;
  logic                           first_pass;
  logic                           step_dir;
  logic                           do_step;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-FRAC:0]       prod_top;
  logic signed [DATA_WIDTH-1:0]   p_sample;
  logic signed [DATA_WIDTH-1:0]   p_avg_next;
  logic signed [DATA_WIDTH:0]     dp;
  logic signed [DATA_WIDTH:0]     v_ref_x;
  logic signed [DATA_WIDTH:0]     step_sum;

  assign product    = v_pv * i_pv;
  assign prod_top   = product[2*DATA_WIDTH-1 : DATA_WIDTH+FRAC-1];
  assign p_avg_next = DATA_WIDTH'(acc >>> AVG_LOG2);
  assign dp         = {p_avg_next[DATA_WIDTH-1], p_avg_next} - {p_prev[DATA_WIDTH-1], p_prev};
  assign v_ref_x    = {v_ref[DATA_WIDTH-1], v_ref};
  assign step_sum   = step_dir ? (v_ref_x + STEP_X) : (v_ref_x - STEP_X);

  // Truncated Q-format power, saturated when the discarded high bits disagree.
  always_comb begin
    // NOTE: assign every always_comb output first so no path leaves it unassigned and infers a latch.
    p_sample = product[DATA_WIDTH+FRAC-1 : FRAC];
    if (!((&prod_top) || (~|prod_top))) begin
      p_sample = product[2*DATA_WIDTH-1] ? P_NEG_SAT : P_POS_SAT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      p_prev      <= '0;
      first_pass  <= 1'b1;
      step_dir    <= 1'b1;
      do_step     <= 1'b0;
      v_ref       <= V_REF_INIT;
      v_ref_valid <= 1'b0;
      p_avg       <= '0;
      dir_up      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      v_ref_valid <= 1'b0;
      busy        <= enable;
      if (!enable) begin
        state      <= IDLE;
        cnt        <= '0;
        acc        <= '0;
        first_pass <= 1'b1;
        v_ref      <= V_REF_INIT;
        dir_up     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            state <= SETTLE;
            cnt   <= '0;
          end
          SETTLE: if (sample_valid) begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              acc   <= '0;
              state <= ACCUM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACCUM: if (sample_valid) begin
            acc <= acc + ACC_W'(p_sample);
            if (cnt == AVG_LAST) begin
              cnt   <= '0;
              state <= COMPUTE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          COMPUTE: begin
            p_avg  <= p_avg_next;
            p_prev <= p_avg_next;
            state  <= UPDATE;
            if (first_pass) begin
              first_pass <= 1'b0;
              step_dir   <= dir_up;
              do_step    <= 1'b1;
            end else if (dp > DB_POS) begin
              step_dir <= dir_up;
              do_step  <= 1'b1;
            end else if (dp < DB_NEG) begin
              step_dir <= ~dir_up;
              do_step  <= 1'b1;
            end else begin
              step_dir <= dir_up;
              do_step  <= 1'b0;
            end
          end
          UPDATE: begin
            v_ref_valid <= 1'b1;
            state       <= SETTLE;
            cnt         <= '0;
            if (do_step) begin
              if (step_sum > REF_MAX_X) begin
                v_ref  <= V_REF_MAX;
                dir_up <= 1'b0;
              end else if (step_sum < REF_MIN_X) begin
                v_ref  <= V_REF_MIN;
                dir_up <= 1'b1;
              end else begin
                v_ref  <= DATA_WIDTH'(step_sum);
                dir_up <= step_dir;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_po_controller.sv
// Scoreboard bench for mppt_po_controller: expected v_ref/dir_up/p_avg are queued
// per iteration and popped on each v_ref_valid pulse.
module tb_mppt_po_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] v_pv = '0;
  logic [31:0] i_pv = '0;

  logic [31:0] vref0, vref1, pavg0, pavg1;
  logic        vld0, vld1, dir0, dir1, busy0, busy1;

  int          dut_sel = 0;
  logic [31:0] m_vref, m_pavg;
  logic        m_vld, m_dir, m_busy;

  assign m_vref = (dut_sel == 1) ? vref1 : vref0;
  assign m_pavg = (dut_sel == 1) ? pavg1 : pavg0;
  assign m_vld  = (dut_sel == 1) ? vld1  : vld0;
  assign m_dir  = (dut_sel == 1) ? dir1  : dir0;
  assign m_busy = (dut_sel == 1) ? busy1 : busy0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] v_ref;
    logic        dir_up;
    logic [31:0] p_avg;
  } exp_t;

  exp_t sb[$];

  mppt_po_controller u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .sample_valid(sample_valid),
    .v_pv(v_pv), .i_pv(i_pv), .v_ref(vref0), .v_ref_valid(vld0),
    .p_avg(pavg0), .dir_up(dir0), .busy(busy0)
  );

  mppt_po_controller #(.V_REF_INIT(32'h0027_C000)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .sample_valid(sample_valid),
    .v_pv(v_pv), .i_pv(i_pv), .v_ref(vref1), .v_ref_valid(vld1),
    .p_avg(pavg1), .dir_up(dir1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Eight back-to-back strobes of one (v, i), then the pulse must land 2 cycles later.
  task automatic run_iter(input string name, input logic [31:0] v, input logic [31:0] i,
                          input logic [31:0] e_vref, input logic e_dir, input logic [31:0] e_pavg);
    exp_t e;
    int   seen;
    e.v_ref  = e_vref;
    e.dir_up = e_dir;
    e.p_avg  = e_pavg;
    sb.push_back(e);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      v_pv = v;
      i_pv = i;
    end
    seen = 0;
    for (int c = 1; c <= 6 && seen == 0; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (m_vld) seen = c;
    end
    checks++;
    if (seen !== 3) begin
      errors++;
      $display("FAIL %s pulse_delay got %0d want 3", name, seen);
    end
    e = sb.pop_front();
    checks++;
    if (m_vref !== e.v_ref) begin
      errors++;
      $display("FAIL %s v_ref got %h want %h", name, m_vref, e.v_ref);
    end
    checks++;
    if (m_dir !== e.dir_up) begin
      errors++;
      $display("FAIL %s dir_up got %b want %b", name, m_dir, e.dir_up);
    end
    checks++;
    if (m_pavg !== e.p_avg) begin
      errors++;
      $display("FAIL %s p_avg got %h want %h", name, m_pavg, e.p_avg);
    end
    @(negedge clk);
    checks++;
    if (m_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width got %b want 0", name, m_vld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (vref0 !== 32'h0012_0000) begin errors++; $display("FAIL reset v_ref got %h want 00120000", vref0); end
    checks++;
    if (dir0 !== 1'b1) begin errors++; $display("FAIL reset dir_up got %b want 1", dir0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy0); end
    checks++;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL reset v_ref_valid got %b want 0", vld0); end
    checks++;
    if (pavg0 !== 32'h0) begin errors++; $display("FAIL reset p_avg got %h want 00000000", pavg0); end
    rst = 1'b0;
  endtask

  task automatic test_climb();
    dut_sel = 0;
    en0 = 1'b1;
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b1) begin errors++; $display("FAIL climb busy got %b want 1", m_busy); end
    run_iter("climb_p90", 32'h0012_0000, 32'h0005_0000, 32'h0012_8000, 1'b1, 32'h005A_0000);
    run_iter("climb_p95", 32'h0013_0000, 32'h0005_0000, 32'h0013_0000, 1'b1, 32'h005F_0000);
  endtask

  task automatic test_reverse();
    run_iter("reverse_p92", 32'h0017_0000, 32'h0004_0000, 32'h0012_8000, 1'b0, 32'h005C_0000);
    run_iter("hold_p92_125", 32'h005C_2000, 32'h0001_0000, 32'h0012_8000, 1'b0, 32'h005C_2000);
  endtask

  task automatic test_saturation();
    run_iter("sat_300x300", 32'h012C_0000, 32'h012C_0000, 32'h0012_0000, 1'b0, 32'h7FFF_FFFF);
    run_iter("neg_m2x3", 32'hFFFE_0000, 32'h0003_0000, 32'h0012_8000, 1'b1, 32'hFFFA_0000);
  endtask

  // Continuous strobes: the two strobes during COMPUTE/UPDATE must be dropped.
  task automatic test_back_to_back();
    exp_t e;
    int   exp_at[2];
    int   npulse;
    exp_at[0] = 11;
    exp_at[1] = 21;
    e.v_ref = 32'h0013_0000; e.dir_up = 1'b1; e.p_avg = 32'h000A_0000; sb.push_back(e);
    e.v_ref = 32'h0013_8000; e.dir_up = 1'b1; e.p_avg = 32'h0014_0000; sb.push_back(e);
    npulse = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (m_vld) begin
        checks++;
        if (npulse >= 2 || c != exp_at[npulse]) begin
          errors++;
          $display("FAIL b2b pulse_cycle got %0d want %0d", c, (npulse < 2) ? exp_at[npulse] : -1);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (m_vref !== e.v_ref) begin errors++; $display("FAIL b2b v_ref got %h want %h", m_vref, e.v_ref); end
          checks++;
          if (m_dir !== e.dir_up) begin errors++; $display("FAIL b2b dir_up got %b want %b", m_dir, e.dir_up); end
          checks++;
          if (m_pavg !== e.p_avg) begin errors++; $display("FAIL b2b p_avg got %h want %h", m_pavg, e.p_avg); end
        end
        npulse++;
      end
      i_pv = 32'h0001_0000;
      sample_valid = (c <= 20);
      if (c >= 5 && c <= 8)        v_pv = 32'h000A_0000;
      else if (c >= 15 && c <= 18) v_pv = 32'h0014_0000;
      else                         v_pv = 32'h0;
    end
    sample_valid = 1'b0;
    checks++;
    if (npulse != 2) begin errors++; $display("FAIL b2b pulse_count got %0d want 2", npulse); end
    while (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_abort();
    int pulses;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      v_pv = 32'h000A_0000;
      i_pv = 32'h0001_0000;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    en0 = 1'b0;
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b want 0", m_busy); end
    checks++;
    if (m_vref !== 32'h0012_0000) begin errors++; $display("FAIL abort v_ref got %h want 00120000", m_vref); end
    checks++;
    if (m_dir !== 1'b1) begin errors++; $display("FAIL abort dir_up got %b want 1", m_dir); end
    pulses = m_vld ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (m_vld) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort pulse_count got %0d want 0", pulses); end
    en0 = 1'b1;
    @(negedge clk);
    run_iter("abort_rerun", 32'h0012_0000, 32'h0005_0000, 32'h0012_8000, 1'b1, 32'h005A_0000);
  endtask

  task automatic test_clamp();
    en0 = 1'b0;
    dut_sel = 1;
    @(negedge clk);
    checks++;
    if (m_vref !== 32'h0027_C000) begin errors++; $display("FAIL clamp init_v_ref got %h want 0027c000", m_vref); end
    en1 = 1'b1;
    @(negedge clk);
    run_iter("clamp_max", 32'h000A_0000, 32'h0001_0000, 32'h0028_0000, 1'b0, 32'h000A_0000);
    run_iter("clamp_back", 32'h0014_0000, 32'h0001_0000, 32'h0027_8000, 1'b0, 32'h0014_0000);
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_climb();
    test_reverse();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mppt_po_controller.md
# mppt_po_controller

Perturb-and-observe maximum power point tracker that sits directly upstream of the PWM generator and drives its `v_ref` input. It consumes strobed PV voltage/current samples in Q16.16 and lets the converter settle after each reference change. It then averages the PV power over a window, compares it with the previous window and steps `v_ref` up or down by a fixed increment, clamped to a safe range.

## Interface
- `DATA_WIDTH`, 32, sample/reference width, signed Q16.16
- `V_REF_INIT`, 32'h0012_0000, reference after reset/disable (18.0 V)
- `V_REF_MIN`, 32'h0005_0000, lower clamp (5.0 V)
- `V_REF_MAX`, 32'h0028_0000, upper clamp (40.0 V)
- `V_STEP`, 32'h0000_8000, perturbation step (0.5 V)
- `P_DEADBAND`, 32'h0000_4000, power hold band (0.25 W)
- `SETTLE_SAMPLES`, 4, samples discarded after each `v_ref` change (≥1)
- `AVG_LOG2`, 2, averaging window is 2^AVG_LOG2 samples

- `clk` in 1 system clock
- `rst` in 1 synchronous, active-high reset
- `enable` in 1 tracking enable; low forces IDLE
- `sample_valid` in 1 single-cycle strobe qualifying `v_pv`/`i_pv`
- `v_pv` in DATA_WIDTH signed PV voltage, Q16.16
- `i_pv` in DATA_WIDTH signed PV current, Q16.16
- `v_ref` out DATA_WIDTH signed reference to PWM generator, Q16.16
- `v_ref_valid` out 1 one-cycle pulse when `v_ref` changes or is re-confirmed
- `p_avg` out DATA_WIDTH signed last averaged power, Q16.16
- `dir_up` out 1 current perturbation direction (1 = increasing)
- `busy` out 1 high in every state except IDLE

## Operation
- States: IDLE, SETTLE, ACCUM, COMPUTE, UPDATE.
- IDLE: `v_ref` = V_REF_INIT, `dir_up` = 1, first-pass flag set. The block moves to SETTLE on the cycle `enable` is seen high.
- SETTLE: counts accepted strobes. After SETTLE_SAMPLES strobes it clears the accumulator and moves to ACCUM.
- ACCUM: for each strobe it adds `sat32((v_pv*i_pv)[47:16])` to a signed accumulator of width DATA_WIDTH+AVG_LOG2.
  - The 64-bit signed product is truncated, not rounded.
  - The value is saturated to 0x7FFF_FFFF / 0x8000_0000 if bits [63:47] are not all equal.
  - After 2^AVG_LOG2 strobes the block moves to COMPUTE.
- COMPUTE: `p_avg` = accumulator >>> AVG_LOG2 (arithmetic shift); dp = p_avg − p_prev, computed in 33 bits. Direction and hold decision:
  - First pass: keep `dir_up`, step, clear the flag.
  - dp > P_DEADBAND: keep direction, step.
  - dp < −P_DEADBAND: invert direction, step.
  - |dp| ≤ P_DEADBAND: hold `v_ref` with no step; direction is unchanged.
  - p_prev ← p_avg.
- UPDATE: candidate = `v_ref` ± V_STEP.
  - If the candidate is > V_REF_MAX, `v_ref` = V_REF_MAX and `dir_up` ← 0.
  - If the candidate is < V_REF_MIN, `v_ref` = V_REF_MIN and `dir_up` ← 1.
  - `v_ref_valid` pulses in all cases, including hold. Next state is SETTLE.
- `sample_valid` is ignored in IDLE, COMPUTE and UPDATE; those samples are dropped.
- `enable` low in any state: next cycle is IDLE with IDLE values, and partial accumulation is discarded. `v_ref_valid` does not pulse.

## Timing
- Reset values: `v_ref` = V_REF_INIT, `v_ref_valid` = 0, `p_avg` = 0, `dir_up` = 1, `busy` = 0. Internally, state is IDLE, p_prev = 0 and the first-pass flag is set.
- `rst` has priority over `enable`.
- The final ACCUM strobe is sampled at edge k:
  - State is COMPUTE after edge k.
  - `p_avg` updates at edge k+1.
  - `v_ref` and `dir_up` update at edge k+2, with `v_ref_valid` high for exactly the cycle after edge k+2.
- Strobes may arrive on consecutive cycles. In SETTLE/ACCUM every high-cycle counts once.
- Total cycles per iteration = time of (SETTLE_SAMPLES + 2^AVG_LOG2) strobes + 2.

## Test plan
- **Reset:** assert `rst` 2 cycles → `v_ref` = 0x0012_0000, `dir_up` = 1, `busy` = 0, `v_ref_valid` = 0.
- **Climb:** enable, back-to-back strobes with v = 18.0 and i = 5.0 (p = 90) → `v_ref` = 0x0012_8000, then p = 95 → 0x0013_0000, `dir_up` = 1. Each `v_ref_valid` pulse comes exactly 2 cycles after the 8th strobe of its iteration.
- **Reverse:** after the climb, p = 92 → `dir_up` = 0 and `v_ref` = 0x0012_8000. Next, p = 92.1 (within deadband) → `v_ref` is held at 0x0012_8000, `v_ref_valid` still pulses and `dir_up` stays 0.
- **Clamp:** V_REF_INIT = 39.75 V with steadily rising power → `v_ref` = 0x0028_0000 and `dir_up` = 0. On the next rising iteration `v_ref` = 39.5 V.
- **Saturation/sign:** v = 300.0 and i = 300.0 → per-sample power saturates to 0x7FFF_FFFF. v = −2.0 and i = 3.0 → `p_avg` = 0xFFFA_0000.
- **Abort:** drop `enable` after 2 ACCUM strobes → IDLE next cycle, `v_ref` = 0x0012_0000 and no `v_ref_valid` pulse. Re-enable → the first pass repeats identically.
